// File: rtl/thermo_expander.sv
`default_nettype none
// ============================================================================
// Module   : thermo_expander
// Purpose  : Expands a count into a thermometer word (parallel) or a
//            WIDTH-cycle unary bit stream (serial).
// Revision : 1.0 - initial release
// ============================================================================
module thermo_expander #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [CW-1:0]    i_in_count,
  input  logic             i_in_serial,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_word,
  output logic             o_ser_valid,
  output logic             o_ser_bit,
  output logic             o_ser_last,
  output logic             o_sat
);

  localparam logic [CW-1:0] c_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0] c_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAR  = 2'd1,
    S_SER  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_alive;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_word;
  logic [CW-1:0]     r_k;
  logic [CW-1:0]     r_n;
  logic              r_sat;

  logic              w_accept;
  logic [CW-1:0]     w_n;
  logic [WIDTH-1:0]  w_thermo;

  // A shift of WIDTH or more clears every bit, so n == WIDTH gives all ones.
  assign w_n      = (i_in_count > c_WIDTH) ? c_WIDTH : i_in_count;
  assign w_thermo = ~({WIDTH{1'b1}} << w_n);

  // r_alive holds off in_ready until the first edge after reset release.
  assign o_in_ready = r_alive &&
                      ((r_state == S_IDLE) || ((r_state == S_PAR) && i_out_ready));
  assign w_accept   = i_in_valid && o_in_ready;

  assign o_out_valid = r_out_valid;
  assign o_out_word  = r_out_word;
  assign o_sat       = r_sat;
  assign o_ser_valid = (r_state == S_SER);
  assign o_ser_bit   = (r_state == S_SER) && (r_k < r_n);
  assign o_ser_last  = (r_state == S_SER) && (r_k == c_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = i_in_serial ? S_SER : S_PAR;
      end
      S_PAR: begin
        if (i_out_ready) begin
          if (w_accept) w_next = i_in_serial ? S_SER : S_PAR;
          else          w_next = S_IDLE;
        end
      end
      S_SER: begin
        if (r_k == c_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alive     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_k         <= '0;
      r_n         <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
      r_sat   <= w_accept && (i_in_count > c_WIDTH);
      if (w_accept && !i_in_serial) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_thermo;
      end else if ((r_state == S_PAR) && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && i_in_serial) begin
        r_n <= w_n;
        r_k <= '0;
      end else if (r_state == S_SER) begin
        r_k <= r_k + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thermo_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_thermo_expander
// Purpose  : Directed and round-trip checks for thermo_expander.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thermo_expander;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [5:0]  i_in_count;
  logic        i_in_serial;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_word;
  logic        o_ser_valid;
  logic        o_ser_bit;
  logic        o_ser_last;
  logic        o_sat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  thermo_expander #(.WIDTH(32), .CW(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_count  (i_in_count),
    .i_in_serial (i_in_serial),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_word  (o_out_word),
    .o_ser_valid (o_ser_valid),
    .o_ser_bit   (o_ser_bit),
    .o_ser_last  (o_ser_last),
    .o_sat       (o_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] thermo(input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) if (i < n) w[i] = 1'b1;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pn [4];
    logic [31:0] pw [4];
    int          q[$];
    int          sent, recv, cyc, e;
    bit          hs, acc;
    logic [31:0] hw;

    pn = '{0, 1, 17, 32};
    pw = '{32'h00000000, 32'h00000001, 32'h0001FFFF, 32'hFFFFFFFF};

    rst_n = 1'b0; i_in_valid = 1'b0; i_in_count = '0; i_in_serial = 1'b0; i_out_ready = 1'b1;
    tick; tick;
    check("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("rst_out_word", o_out_word, 32'd0);
    check("rst_ser_valid", {31'b0, o_ser_valid}, 32'd0);
    check("rst_ser_bit", {31'b0, o_ser_bit}, 32'd0);
    check("rst_ser_last", {31'b0, o_ser_last}, 32'd0);
    check("rst_sat", {31'b0, o_sat}, 32'd0);
    rst_n = 1'b1;
    tick;
    check("rst_in_ready", {31'b0, o_in_ready}, 32'd1);

    // Back-to-back parallel words
    for (int i = 0; i < 4; i++) begin
      i_in_valid = 1'b1; i_in_count = 6'(pn[i]); i_in_serial = 1'b0;
      #1;
      check("par_in_ready", {31'b0, o_in_ready}, 32'd1);
      tick;
      check("par_word", o_out_word, pw[i]);
      check("par_valid", {31'b0, o_out_valid}, 32'd1);
      check("par_sat", {31'b0, o_sat}, 32'd0);
    end
    i_in_valid = 1'b0;
    tick;
    check("par_drop", {31'b0, o_out_valid}, 32'd0);

    // Hold under backpressure with a pending request
    i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_count = 6'd5;
    tick;
    i_in_count = 6'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_in_ready", {31'b0, o_in_ready}, 32'd0);
      check("hold_word", o_out_word, 32'h0000001F);
      check("hold_valid", {31'b0, o_out_valid}, 32'd1);
      tick;
    end
    check("hold_word_end", o_out_word, 32'h0000001F);
    i_out_ready = 1'b1;
    #1;
    check("pend_in_ready", {31'b0, o_in_ready}, 32'd1);
    tick;
    check("pend_word", o_out_word, 32'h00000007);
    check("pend_valid", {31'b0, o_out_valid}, 32'd1);
    i_in_valid = 1'b0;
    tick;
    check("pend_drop", {31'b0, o_out_valid}, 32'd0);

    // Serial n=3 frame
    i_in_valid = 1'b1; i_in_serial = 1'b1; i_in_count = 6'd3;
    tick;
    i_in_valid = 1'b0; i_in_serial = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("ser3_valid", {31'b0, o_ser_valid}, 32'd1);
      check("ser3_bit", {31'b0, o_ser_bit}, (i < 3) ? 32'd1 : 32'd0);
      check("ser3_last", {31'b0, o_ser_last}, (i == 31) ? 32'd1 : 32'd0);
      check("ser3_in_ready", {31'b0, o_in_ready}, 32'd0);
      check("ser3_out_valid", {31'b0, o_out_valid}, 32'd0);
      tick;
    end
    check("ser3_gap_valid", {31'b0, o_ser_valid}, 32'd0);
    check("ser3_gap_in_ready", {31'b0, o_in_ready}, 32'd1);

    // Saturation, parallel then serial
    i_in_valid = 1'b1; i_in_count = 6'd40; i_in_serial = 1'b0;
    tick;
    check("sat40_word", o_out_word, 32'hFFFFFFFF);
    check("sat40_pulse", {31'b0, o_sat}, 32'd1);
    i_in_valid = 1'b0;
    tick;
    check("sat40_clear", {31'b0, o_sat}, 32'd0);
    check("sat40_drop", {31'b0, o_out_valid}, 32'd0);
    i_in_valid = 1'b1; i_in_count = 6'd63; i_in_serial = 1'b1;
    tick;
    i_in_valid = 1'b0; i_in_serial = 1'b0;
    check("sat63_pulse", {31'b0, o_sat}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      check("sat63_bit", {31'b0, o_ser_bit & o_ser_valid}, 32'd1);
      if (i == 1) check("sat63_clear", {31'b0, o_sat}, 32'd0);
      tick;
    end
    check("sat63_gap", {31'b0, o_ser_valid}, 32'd0);

    // Asynchronous reset in the middle of a frame
    i_in_valid = 1'b1; i_in_count = 6'd20; i_in_serial = 1'b1;
    tick;
    i_in_valid = 1'b0; i_in_serial = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    check("mid_bit10", {31'b0, o_ser_bit & o_ser_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ser_valid", {31'b0, o_ser_valid}, 32'd0);
    check("mid_rst_ser_bit", {31'b0, o_ser_bit}, 32'd0);
    check("mid_rst_out_valid", {31'b0, o_out_valid}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("mid_in_ready", {31'b0, o_in_ready}, 32'd1);
    check("mid_no_resume", {31'b0, o_ser_valid}, 32'd0);
    i_in_valid = 1'b1; i_in_count = 6'd2;
    tick;
    check("mid_par2", o_out_word, 32'h00000003);
    i_in_valid = 1'b0;
    tick;

    // Random round trip with random backpressure
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
      i_in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_in_count  = 6'($urandom_range(0, 32));
      i_in_serial = 1'b0;
      i_out_ready = 1'($urandom_range(0, 1));
      #1;
      hs  = o_out_valid && i_out_ready;
      acc = i_in_valid && o_in_ready;
      hw  = o_out_word;
      if (o_ser_valid) check("rt_no_serial", {31'b0, o_ser_valid}, 32'd0);
      if (hs) begin
        if (q.size() == 0) begin
          check("rt_dup_word", 32'd1, 32'd0 + 32'(q.size()));
        end else begin
          e = q.pop_front();
          check("rt_popcount", 32'($countones(hw)), 32'(e));
          check("rt_word", hw, thermo(e));
          recv++;
        end
      end
      if (acc) begin
        q.push_back(int'(i_in_count));
        sent++;
      end
      tick;
      cyc++;
    end
    i_in_valid = 1'b0;
    check("rt_sent", 32'(sent), 32'd1000);
    check("rt_recv", 32'(recv), 32'd1000);
    check("rt_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
